// File: rtl/jtkicker_psgseq_pkg.sv
// Shared types and constants for the PSG write scheduler.
package jtkicker_psgseq_pkg;

    // Engine states for replaying one queued write to a PSG.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    // Queue entry: target chip plus the data byte to write.
    localparam int ENTRY_W = 9;

    // Width of the ready-handshake timeout counter.
    localparam int TMO_W = 10;

    typedef struct packed {
        logic       chip;
        logic [7:0] data;
    } entry_t;

    // One-hot mask of the chip addressed by an entry.
    function automatic logic [1:0] chip_mask(input logic chip);
        return chip ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/jtkicker_psgseq_fifo.sv
// Circular write queue with two push ports (port 0 lands first) and one pop.
module jtkicker_psgseq_fifo #(
    parameter int AW = 2,
    parameter int W  = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push0,
    input  logic [W-1:0] din0,
    input  logic         push1,
    input  logic [W-1:0] din1,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  free
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;

    // Occupancy and status; free slots include the slot released by a same-cycle pop.
    always_comb begin
        count  = wr_ptr - rd_ptr;
        empty  = (count == '0);
        full   = (count == DEPTH_C);
        pop_ok = pop & ~empty;
        free   = DEPTH_C - count + {{AW{1'b0}}, pop_ok};
        wa0    = wr_ptr[AW-1:0];
        wa1    = wa0 + {{(AW-1){1'b0}}, push0};
        dout   = mem[rd_ptr[AW-1:0]];
    end

    // Storage writes: port 0 takes the first free slot, port 1 the one after it.
    always_ff @(posedge clk) begin
        if (push0) mem[wa0] <= din0;
        if (push1) mem[wa1] <= din1;
    end

    // Pointer update; the extra MSB keeps full and empty distinct.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push0} + {{AW{1'b0}}, push1};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/jtkicker_psgseq.sv
// Queues CPU writes to the two PSGs and replays them one at a time with a
// cs / wr strobe and the chip's ready handshake.
//
// Ready handshake: psg_rdy[n] high means chip n is idle and may take a write.
// A strobe is only started after rdy is seen high; the chip acknowledges by
// dropping rdy and signals completion by raising it again. A stuck rdy is
// bounded by the timeout counter.
module jtkicker_psgseq
    import jtkicker_psgseq_pkg::*;
#(
    parameter int FIFO_AW  = 2,
    parameter int WAIT_MAX = 1023
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cpu_cen,
    input  logic [1:0] latch_we,
    input  logic [1:0] trig_we,
    input  logic [7:0] cpu_dout,
    input  logic       ovf_clr,
    input  logic [1:0] psg_rdy,
    output logic [7:0] psg_din,
    output logic [1:0] psg_cs_n,
    output logic [1:0] psg_wr_n,
    output logic       busy,
    output logic [1:0] ovf
);

    localparam logic [TMO_W-1:0] WAIT_MAX_C = TMO_W'(WAIT_MAX);

    logic [1:0][7:0]     lat;
    logic                req0, req1;
    logic                acc0, acc1;
    logic [1:0]          drop;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic                fifo_full, fifo_empty;
    logic [FIFO_AW:0]    fifo_free;
    logic                pop;

    state_t              state, state_nx;
    logic [TMO_W-1:0]    cnt, cnt_nx;
    entry_t              work;
    logic                rdy_sel;
    logic [1:0]          cs_n_nx, wr_n_nx;
    logic                busy_nx;

    // CPU-side data latches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat <= '0;
        end else if (cpu_cen) begin
            if (latch_we[0]) lat[0] <= cpu_dout;
            if (latch_we[1]) lat[1] <= cpu_dout;
        end
    end

    // Push acceptance: chip 0 claims a slot first, chip 1 needs a second one if both fire.
    always_comb begin
        req0 = cpu_cen & trig_we[0];
        req1 = cpu_cen & trig_we[1];
        acc0 = req0 & (~fifo_full | pop);
        acc1 = req1 & (fifo_free > {{FIFO_AW{1'b0}}, acc0});
        drop = {req1 & ~acc1, req0 & ~acc0};
    end

    jtkicker_psgseq_fifo #(
        .AW (FIFO_AW),
        .W  (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push0 (acc0),
        .din0  ({1'b0, lat[0]}),
        .push1 (acc1),
        .din1  ({1'b1, lat[1]}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    // Sticky drop flags; a drop in the same cycle as a clear still sets the flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 2'b00;
        end else if (cpu_cen & ovf_clr) begin
            ovf <= drop;
        end else begin
            ovf <= ovf | drop;
        end
    end

    assign pop     = (state == IDLE) & ~fifo_empty;
    assign rdy_sel = psg_rdy[work.chip];

    // Engine next state and timeout counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nx = SETUP;
            end
            SETUP: begin
                if (rdy_sel) state_nx = STROBE;
            end
            STROBE: begin
                state_nx = WAIT_LO;
                cnt_nx   = '0;
            end
            WAIT_LO: begin
                if (!rdy_sel || cnt == WAIT_MAX_C) state_nx = WAIT_HI;
                else                               cnt_nx   = cnt + 1'b1;
            end
            WAIT_HI: begin
                if (rdy_sel || cnt == WAIT_MAX_C) state_nx = IDLE;
                else                              cnt_nx   = cnt + 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Chip-side strobes derived from the current state; registered so they never glitch.
    always_comb begin
        cs_n_nx = 2'b11;
        wr_n_nx = 2'b11;
        busy_nx = ~fifo_empty | (state != IDLE);
        case (state)
            SETUP, WAIT_LO, WAIT_HI: begin
                cs_n_nx = ~chip_mask(work.chip);
            end
            STROBE: begin
                cs_n_nx = ~chip_mask(work.chip);
                wr_n_nx = ~chip_mask(work.chip);
            end
            default: begin
                cs_n_nx = 2'b11;
            end
        endcase
    end

    // Engine registers: state, counter, working entry and chip-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            psg_din  <= 8'h00;
            psg_cs_n <= 2'b11;
            psg_wr_n <= 2'b11;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            psg_cs_n <= cs_n_nx;
            psg_wr_n <= wr_n_nx;
            busy     <= busy_nx;
            if (pop)             work    <= fifo_dout;
            if (state == SETUP)  psg_din <= work.data;
        end
    end

endmodule

// File: tb/tb_jtkicker_psgseq.sv
// Directed bench for the PSG write scheduler.
module tb_jtkicker_psgseq;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b1;
    logic       cpu_cen  = 1'b1;
    logic [1:0] latch_we = 2'b00;
    logic [1:0] trig_we  = 2'b00;
    logic [7:0] cpu_dout = 8'h00;
    logic       ovf_clr  = 1'b0;
    logic [1:0] psg_rdy  = 2'b11;
    logic [7:0] psg_din;
    logic [1:0] psg_cs_n;
    logic [1:0] psg_wr_n;
    logic       busy;
    logic [1:0] ovf;

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         n_strobes = 0;
    int         n_exp     = 0;
    logic [8:0] exp_q[$];
    logic       prev_wr_low = 1'b0;
    logic       mon_chip;
    int         gap;

    jtkicker_psgseq #(
        .FIFO_AW  (2),
        .WAIT_MAX (1023)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cpu_cen  (cpu_cen),
        .latch_we (latch_we),
        .trig_we  (trig_we),
        .cpu_dout (cpu_dout),
        .ovf_clr  (ovf_clr),
        .psg_rdy  (psg_rdy),
        .psg_din  (psg_din),
        .psg_cs_n (psg_cs_n),
        .psg_wr_n (psg_wr_n),
        .busy     (busy),
        .ovf      (ovf)
    );

    // Clock: ~24 MHz.
    always #21 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU bus cycle: strobes are held across one rising edge, then dropped.
    task automatic drive(input logic [1:0] lw, input logic [1:0] tw,
                         input logic [7:0] d, input logic clr);
        latch_we = lw;
        trig_we  = tw;
        cpu_dout = d;
        ovf_clr  = clr;
        @(negedge clk);
        latch_we = 2'b00;
        trig_we  = 2'b00;
        cpu_dout = 8'h00;
        ovf_clr  = 1'b0;
    endtask

    task automatic expect_wr(input logic chip, input logic [7:0] data);
        exp_q.push_back({chip, data});
        n_exp++;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    task automatic wait_wr(input int chip, input int budget, input string tag, output int cyc);
        cyc = 0;
        while (psg_wr_n[chip] !== 1'b0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(psg_wr_n[chip]), 32'h0);
    endtask

    // Scoreboard: every strobe seen on the chip side is checked against the expected queue.
    always @(negedge clk) begin
        if (rstn && psg_wr_n != 2'b11) begin
            n_strobes++;
            mon_chip = psg_wr_n[0];
            check("wr_onehot", 32'(psg_wr_n == 2'b10 || psg_wr_n == 2'b01), 32'h1);
            check("wr_width", 32'(prev_wr_low), 32'h0);
            check("cs_at_wr", 32'(psg_cs_n), 32'(psg_wr_n));
            check("rdy_at_wr", 32'(psg_rdy[mon_chip]), 32'h1);
            check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) check("wr_data", 32'({mon_chip, psg_din}), 32'(exp_q.pop_front()));
        end
        prev_wr_low = rstn && (psg_wr_n != 2'b11);
    end

    initial begin
        // Reset values.
        #1 rstn = 1'b0;
        #1;
        check("rst_cs_n", 32'(psg_cs_n), 32'h3);
        check("rst_wr_n", 32'(psg_wr_n), 32'h3);
        check("rst_din", 32'(psg_din), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Strobes with cpu_cen low are ignored.
        cpu_cen = 1'b0;
        drive(2'b11, 2'b11, 8'h77, 1'b0);
        cpu_cen = 1'b1;
        repeat (3) @(negedge clk);
        check("cen_gate_busy", 32'(busy), 32'h0);
        check("cen_gate_ovf", 32'(ovf), 32'h0);

        // Single write: strobe exactly 3 clk after the accepted edge.
        expect_wr(1'b0, 8'h9F);
        drive(2'b01, 2'b00, 8'h9F, 1'b0);
        drive(2'b00, 2'b01, 8'h00, 1'b0);
        check("sw_k0_cs", 32'(psg_cs_n), 32'h3);
        check("sw_k0_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("sw_k1_busy", 32'(busy), 32'h1);
        check("sw_k1_cs", 32'(psg_cs_n), 32'h3);
        @(negedge clk);
        check("sw_k2_cs", 32'(psg_cs_n), 32'h2);
        check("sw_k2_wr", 32'(psg_wr_n), 32'h3);
        @(negedge clk);
        check("sw_k3_wr", 32'(psg_wr_n), 32'h2);
        check("sw_k3_cs", 32'(psg_cs_n), 32'h2);
        check("sw_k3_din", 32'(psg_din), 32'h9F);
        @(negedge clk);
        check("sw_k4_wr", 32'(psg_wr_n), 32'h3);
        check("sw_k4_cs", 32'(psg_cs_n), 32'h2);
        wait_idle(1200, "sw_idle");

        // Simultaneous triggers; a same-cycle latch write does not affect the pushed value.
        expect_wr(1'b0, 8'h80);
        expect_wr(1'b1, 8'hC0);
        expect_wr(1'b0, 8'hAA);
        drive(2'b01, 2'b00, 8'h80, 1'b0);
        drive(2'b10, 2'b00, 8'hC0, 1'b0);
        drive(2'b01, 2'b11, 8'hAA, 1'b0);
        drive(2'b00, 2'b01, 8'h00, 1'b0);
        wait_idle(3400, "sim_idle");

        // Ready handshake: rdy drops 2 clk after the strobe and stays low 32 clk.
        expect_wr(1'b0, 8'h11);
        expect_wr(1'b0, 8'h22);
        drive(2'b01, 2'b00, 8'h11, 1'b0);
        drive(2'b01, 2'b01, 8'h22, 1'b0);
        drive(2'b00, 2'b01, 8'h00, 1'b0);
        wait_wr(0, 20, "hs_first_wr", gap);
        repeat (2) @(negedge clk);
        psg_rdy[0] = 1'b0;
        repeat (32) @(negedge clk);
        psg_rdy[0] = 1'b1;
        wait_wr(0, 100, "hs_second_wr", gap);
        check("hs_after_rise", 32'(gap >= 2), 32'h1);
        check("hs_spacing", 32'(gap + 34 >= 37), 32'h1);
        wait_idle(1200, "hs_idle");

        // Overflow: 5 of 6 back-to-back writes fit (4 queued plus the one popped).
        check("ovf_start", 32'(ovf), 32'h0);
        for (int i = 0; i < 5; i++) expect_wr(1'b0, 8'h30 + 8'(i));
        drive(2'b01, 2'b00, 8'h30, 1'b0);
        for (int i = 0; i < 5; i++) drive(2'b01, 2'b01, 8'h31 + 8'(i), 1'b0);
        check("ovf_before_6th", 32'(ovf), 32'h0);
        drive(2'b01, 2'b01, 8'h36, 1'b0);
        check("ovf_after_6th", 32'(ovf), 32'h1);
        drive(2'b00, 2'b01, 8'h00, 1'b1);
        check("ovf_set_wins", 32'(ovf), 32'h1);
        drive(2'b00, 2'b00, 8'h00, 1'b1);
        check("ovf_cleared", 32'(ovf), 32'h0);
        wait_idle(6000, "ovf_idle");

        // Reset mid-strobe releases cs/wr without a clock and drops the queue.
        expect_wr(1'b0, 8'hA1);
        drive(2'b01, 2'b00, 8'hA1, 1'b0);
        drive(2'b01, 2'b01, 8'hA2, 1'b0);
        drive(2'b00, 2'b01, 8'h00, 1'b0);
        wait_wr(0, 20, "rst_mid_wr", gap);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_cs", 32'(psg_cs_n), 32'h3);
        check("rst_mid_wr_n", 32'(psg_wr_n), 32'h3);
        check("rst_mid_din", 32'(psg_din), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_after_busy", 32'(busy), 32'h0);
        check("rst_after_cs", 32'(psg_cs_n), 32'h3);
        check("rst_after_ovf", 32'(ovf), 32'h0);

        // Timeout on chip 1 with rdy tied high; latch 1 was cleared by reset.
        expect_wr(1'b1, 8'h00);
        drive(2'b00, 2'b10, 8'h00, 1'b0);
        repeat (1028) @(negedge clk);
        check("tmo_cs_held", 32'(psg_cs_n), 32'h1);
        check("tmo_busy_held", 32'(busy), 32'h1);
        @(negedge clk);
        check("tmo_cs_released", 32'(psg_cs_n), 32'h3);
        check("tmo_busy_fell", 32'(busy), 32'h0);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("strobe_count", 32'(n_strobes), 32'(n_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtkicker_psgseq.md
# jtkicker_psgseq

Write scheduler for the main board's two SN76489-class PSGs (jt89 instances). The CPU side only latches a data byte and fires a trigger per chip, with no bus stall. This block queues the writes in CPU order and replays each one to its chip. Each replay drives data and chip select, issues a one-cycle write strobe, and waits for the chip's ready handshake before starting the next write. It sits between the main-CPU address decoder and the two PSG cores, in place of direct cs/wr wiring.

## Interface
Parameters:
- FIFO_AW, 2, log2 of queue depth (depth 4).
- WAIT_MAX, 1023, clk cycles allowed for the ready handshake before a forced timeout.

Ports:
- clk  in  1  system clock, 24 MHz.
- rstn  in  1  asynchronous, active-low reset.
- cpu_cen  in  1  CPU bus clock enable; CPU-side strobes are sampled only when high.
- latch_we  in  2  bit n: load cpu_dout into data latch n.
- trig_we  in  2  bit n: enqueue a write of latch n to chip n.
- cpu_dout  in  8  CPU data bus.
- ovf_clr  in  1  clears the ovf flags; sampled on cpu_cen.
- psg_rdy  in  2  ready from chip n; high = idle.
- psg_din  out  8  data presented to both chips.
- psg_cs_n  out  2  chip select, active low.
- psg_wr_n  out  2  write strobe, active low.
- busy  out  1  queue non-empty or engine not IDLE.
- ovf  out  2  sticky flag: a trigger to chip n was dropped because the queue was full.

## Operation
- **Latches:** two 8-bit data latches. Each loads cpu_dout when cpu_cen & latch_we[n].
- **Enqueue:** cpu_cen & trig_we[n] pushes the entry {n, latch[n]}, 9 bits.
  - The push uses the latch value before any latch_we in the same cycle.
  - If both trigger bits are set in one cycle, chip 0 is pushed first, then chip 1.
- **Queue:** circular FIFO with 2^FIFO_AW entries. Pointers are FIFO_AW+1 bits so full/empty is unambiguous.
  - Free slots are counted after any pop in the same cycle.
  - An entry that does not fit is dropped and sets ovf[n].
  - ovf_clr & cpu_cen clears ovf. A set event in the same cycle wins over the clear.
- **Engine FSM:**
  - IDLE: if the FIFO is non-empty, pop its head into a working register, then go to SETUP.
  - SETUP: drive psg_din with the data and assert psg_cs_n[n]=0. Stay here until psg_rdy[n]=1, then go to STROBE.
  - STROBE: hold cs, assert psg_wr_n[n]=0 for exactly 1 clk, then go to WAIT_LO.
  - WAIT_LO: hold cs and data. Go to WAIT_HI when psg_rdy[n]=0, or when the timeout counter reaches WAIT_MAX.
  - WAIT_HI: go to IDLE and release cs when psg_rdy[n]=1, or on timeout.
  - The timeout counter is 10 bits. It clears on entry to WAIT_LO and is not reset again at WAIT_HI.
- **Unselected chip:** always has cs_n=1 and wr_n=1.
- **Order:** writes are issued strictly in FIFO order. A write to one chip never overtakes an earlier write to the other.

## Timing
- **Reset values** (asynchronous, rstn low):
  - psg_cs_n=2'b11, psg_wr_n=2'b11, psg_din=0.
  - busy=0, ovf=0.
  - Latches 0, FIFO empty, FSM in IDLE, timeout counter 0.
- **Reset mid-transfer:** rstn low releases cs and wr immediately, without waiting for a clock. The queued entries are lost.
- **First strobe latency:** a trigger accepted at edge k into an empty FIFO, with psg_rdy[n] already high, gives:
  - pop at k+1 (IDLE);
  - cs low from k+2 (SETUP);
  - wr_n low during k+3 only (STROBE).
- **Strobe width:** wr_n is never low for more than 1 clk and is never asserted while psg_rdy[n]=0.
- **Back-to-back writes:** the minimum spacing between strobes is 5 clk plus the chip's ready-low time.
- **busy:** registered. It rises the cycle after the first accepted push and falls the cycle after the engine returns to IDLE with the FIFO empty.
- **Timeout:** after WAIT_MAX+1 cycles in the wait states, the engine proceeds as if ready had been seen. No flag is raised.

## Structure
- Shared package `jtkicker_psgseq_pkg`:
  - FSM state enum: IDLE, SETUP, STROBE, WAIT_LO, WAIT_HI.
  - Entry width constant (9).
  - Timeout counter width (10).
- One sub-module, `jtkicker_psgseq_fifo`:
  - parameterised depth;
  - dual push with priority to port 0;
  - single pop, with push and pop allowed in the same cycle;
  - full, empty and free-count outputs.
- The FSM, latches and ovf logic live in the top module.

## Test plan
- **Reset:** hold rstn low mid-STROBE → cs_n=2'b11 and wr_n=2'b11 combinationally. After release, busy=0 and ovf=0.
- **Single write:** latch0=8'h9F, trig_we=2'b01, rdy held high → wr_n[0] low for exactly 1 clk, 3 clk after the accepted edge, with psg_din=8'h9F and cs_n=2'b10.
- **Simultaneous triggers:** latch0=8'h80, latch1=8'hC0, trig_we=2'b11 in one cycle → strobes reach chip 0 with 8'h80, then chip 1 with 8'hC0, in that order.
- **Ready handshake:** model rdy dropping 2 clk after the strobe for 32 clk → the next strobe comes no earlier than rdy rising plus SETUP, and wr_n is never low while rdy=0.
- **Overflow:** hold rdy[0]=1 with no drop, push 6 writes to chip 0 back-to-back → 5 are accepted (4 queued plus 1 popped), the 6th sets ovf=2'b01, and ovf_clr returns ovf to 0.
- **Timeout:** tie rdy[1]=1 permanently, trigger chip 1 → the engine leaves WAIT_LO after WAIT_MAX+1 clk and busy falls afterwards.
